// File: rtl/cpu_io_pkg.sv
// Shared types and defaults for the CPU output UART path.
// Transmit FSM states and UART constants.
package cpu_io_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int         UART_CLKS_PER_BIT = 434;
  localparam logic [7:0] UART_END_BYTE     = 8'h0A;

endpackage

// File: rtl/cpu_out_uart_tx_if.sv
// CPU byte-stream bundle: output strobe, byte, end flag.
// master is the CPU side, slave is the UART consumer.
interface cpu_out_uart_tx_if;

  logic       outFlag;
  logic [7:0] cpuOut;
  logic       endFlag;

  modport master (
    output outFlag,
    output cpuOut,
    output endFlag
  );

  modport slave (
    input outFlag,
    input cpuOut,
    input endFlag
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO, power-of-2 depth.
// Head entry is visible on dout without a read cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees a slot for a push into a full FIFO.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/cpu_out_uart_tx.sv
// Captures CPU output bytes on strobe edges, queues them,
// and sends them as 8N1 frames, ending with a terminator byte.
module cpu_out_uart_tx
  import cpu_io_pkg::*;
#(
  parameter int         CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [7:0] END_BYTE     = UART_END_BYTE
) (
  input  logic               clock,
  input  logic               reset,
  cpu_out_uart_tx_if.slave   cpu,
  output logic               tx,
  output logic               busy,
  output logic               overflow,
  output logic               done
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_q;
  tx_state_t     state_d;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [7:0]    shift_q;
  logic          flag_q;
  logic          end_q;
  logic          end_pend;
  logic          is_end;
  logic          cap;
  logic          end_rise;
  logic          push;
  logic          pop;
  logic          load_end;
  logic          tick;
  logic          f_empty;
  logic          f_full;
  logic [7:0]    f_dout;

  assign cap      = cpu.outFlag & ~flag_q;
  assign end_rise = cpu.endFlag & ~end_q;
  assign push     = cap & ~done;
  assign tick     = (cnt_q == BIT_LAST);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .din   (cpu.cpuOut),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full)
  );

  // Edge detectors, sticky flags and end request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_q   <= 1'b0;
      end_q    <= 1'b0;
      end_pend <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      flag_q <= cpu.outFlag;
      end_q  <= cpu.endFlag;
      busy   <= ~f_empty | (state_q != IDLE);
      if (end_rise && !done) end_pend <= 1'b1;
      else if (load_end)     end_pend <= 1'b0;
      if (push && f_full && !pop) overflow <= 1'b1;
      if (state_q == STOP && tick && is_end) done <= 1'b1;
    end
  end

  // FSM state, bit timer, bit index and frame payload.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      is_end  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q || tick || state_q == IDLE)
        cnt_q <= '0;
      else
        cnt_q <= cnt_q + CW'(1);
      if (state_q != DATA) idx_q <= '0;
      else if (tick)       idx_q <= idx_q + 3'd1;
      if (pop) begin
        shift_q <= f_dout;
        is_end  <= 1'b0;
      end else if (load_end) begin
        shift_q <= END_BYTE;
        is_end  <= 1'b1;
      end
    end
  end

  // Next state, FIFO pop, terminator load and line level.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    load_end = 1'b0;
    tx       = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          pop     = 1'b1;
          state_d = START;
        end else if (end_pend) begin
          load_end = 1'b1;
          state_d  = START;
        end
      end
      START: begin
        tx = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[idx_q];
        if (tick && idx_q == 3'd7) state_d = STOP;
      end
      STOP: begin
        if (tick) state_d = IDLE;
      end
    endcase
  end

endmodule

// File: doc/cpu_out_uart_tx.md
# cpu_out_uart_tx

Output-side consumer of the CPU's byte stream. It sits on the 50 MHz `clock` domain beside the CPU top level and captures each byte the CPU presents on its 8-bit output when the output strobe rises. Captured bytes are buffered in a small FIFO and serialized as UART 8N1 frames to the host PC. When the CPU raises its end-of-program flag, the block sends one terminator byte after the queue drains, then reports completion.

## Interface
Parameters:
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200).
- `FIFO_DEPTH`, 16: byte slots in the buffer; must be a power of 2 and ≥ 2.
- `END_BYTE`, 8'h0A: terminator byte sent after `endFlag`.

Ports:
- `clock` in 1: single clock for all logic.
- `reset` in 1: asynchronous, active-low reset.
- `outFlag` in 1: CPU output-valid level; held high for many `clock` cycles per byte.
- `cpuOut` in 8: CPU output byte; stable whenever `outFlag` is high.
- `endFlag` in 1: CPU end-of-program level.
- `tx` out 1: UART serial line; idles high.
- `busy` out 1: FIFO not empty or transmitter not IDLE.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `done` out 1: sticky; set when the `END_BYTE` stop bit completes.

## Operation
- **Reset:** `reset`=0 forces `tx`=1, `busy`=0, `overflow`=0, `done`=0, FIFO empty, FSM in IDLE, edge registers at 0, end-pending cleared. Reset takes effect immediately, including mid-frame.
- **Capture:** `flag_q` registers `outFlag`. Capture fires on the edge where `outFlag`=1 and `flag_q`=0. At that edge `cpuOut` is pushed into the FIFO, giving exactly one push per strobe regardless of its length.
- **Full FIFO:** a capture into a full FIFO drops the byte and sets `overflow`. If a pop happens on the same edge, the push is accepted and no overflow occurs.
- **End request:** a rising `endFlag` (edge-detected the same way) sets end-pending. The FSM sends `END_BYTE` only when end-pending is set, the FIFO is empty, and the FSM is in IDLE. After that frame, `done`=1 and further captures are ignored until reset.
- **FSM states:**
  - IDLE: `tx`=1. If the FIFO is non-empty, pop into the shift register and go to START. Otherwise, if the end condition holds, load `END_BYTE` and go to START.
  - START: `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA: 8 bits, LSB first, `CLKS_PER_BIT` cycles each. A 3-bit index counts 0 to 7.
  - STOP: `tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- **Counters:** the bit-time counter is `$clog2(CLKS_PER_BIT)` bits wide, counts 0 to `CLKS_PER_BIT`-1, and clears on every state change. The FIFO count is `$clog2(FIFO_DEPTH)+1` bits wide. Read and write pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Capture latency:** byte pushed at edge E; with the FIFO previously empty and the FSM in IDLE, `tx` goes low at edge E+1.
- **Frame length:** 10·`CLKS_PER_BIT` cycles. Back-to-back frames are separated by exactly one IDLE cycle, for a period of 10·`CLKS_PER_BIT`+1.
- **`done` timing:** `done` is asserted at the same edge at which STOP of `END_BYTE` exits to IDLE.
- **`busy` timing:** `busy` is registered and follows FIFO count and state with one cycle of latency.
- **Input synchrony:** `outFlag`, `cpuOut`, and `endFlag` come from logic clocked by the divided clock, which is derived from `clock`. They are treated as synchronous; no synchronizers are used.

## Structure
- **Package `cpu_io_pkg`:** `tx_state_t` enum {IDLE, START, DATA, STOP} and the default constants `UART_CLKS_PER_BIT` and `UART_END_BYTE`.
- **Sub-module `sync_fifo`:** parameterized width and depth; ports push, pop, din, dout, empty, full. Same clock and reset as the parent. dout shows the head entry combinationally.
- **Top:** the edge detectors, end-pending flag, and transmit FSM remain in `cpu_out_uart_tx`.

## Test plan
All scenarios use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- **Single byte:** one `outFlag` pulse of 20 cycles with `cpuOut`=8'hA5 -> `tx` goes low 1 cycle after capture. Bits sent are 1,0,1,0,0,1,0,1 (LSB first), 4 cycles each, then stop. Exactly one frame, 40 cycles.
- **Back-to-back:** 3 strobes in close succession (8'h01, 8'h02, 8'h03) -> three frames in order, each 41 cycles apart, `busy` high throughout.
- **Overflow:** 6 strobes while the first frame is in progress -> 4 slots fill, the excess bytes are dropped, `overflow`=1. The bytes that were stored are sent in order.
- **Push with pop on full FIFO:** strobe on the exact edge IDLE pops from a full FIFO -> byte accepted, `overflow` stays 0.
- **End sequence:** two bytes queued, then `endFlag` rises -> both bytes sent, then 8'h0A. `done`=1 at the end of its stop bit. A later strobe produces no frame.
- **Reset mid-frame:** `reset`=0 during DATA -> `tx`=1 immediately, all flags cleared. After release, the FIFO is empty and no frame is emitted.
